// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC register, ROM addressing and a small prefetch FIFO to decode.
// Optional IFU_FAULT_CHECK_EN adds per-entry fault tagging (out-of-range or misaligned fetch).
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned IMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins_data,
`ifdef IFU_FAULT_CHECK_EN
  output logic        ins_fault,
`endif
  output logic [31:0] ins_pc
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  logic [31:0]      fpc;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] wptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      last_pc;
  logic [31:0]      last_data;

  logic             do_deq;
  logic             do_enq;
  logic [31:0]      enq_data;

`ifdef IFU_FAULT_CHECK_EN
  logic             fault_q [DEPTH];
  logic             misalign_q;
  logic             enq_fault;

  // Out-of-range word index or the first fetch after a misaligned redirect is tagged and replaced by a NOP.
  always_comb begin
    enq_fault = (fpc[31:2] >= 30'(IMEM_WORDS)) || misalign_q;
    enq_data  = enq_fault ? NOP_INSN : imem_rdata;
  end

  assign ins_fault = ins_valid ? fault_q[rptr] : 1'b0;
`else
  assign enq_data = imem_rdata;
`endif

  assign imem_addr = {2'b00, fpc[31:2]};
  assign ins_valid = (count != '0);
  assign ins_data  = ins_valid ? data_q[rptr] : last_data;
  assign ins_pc    = ins_valid ? pc_q[rptr]   : last_pc;

  // Redirect overrides both sides of the FIFO in the same cycle.
  always_comb begin
    do_deq = ins_valid && ins_ready && !redirect_valid;
    do_enq = !redirect_valid && ((count < CNT_W'(DEPTH)) || do_deq);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc       <= RESET_PC;
      rptr      <= '0;
      wptr      <= '0;
      count     <= '0;
      last_pc   <= '0;
      last_data <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      // Keep the most recent head so outputs hold while the FIFO is empty.
      if (ins_valid) begin
        last_pc   <= pc_q[rptr];
        last_data <= data_q[rptr];
      end
      if (redirect_valid) begin
        fpc   <= redirect_pc & 32'hFFFF_FFFC;
        rptr  <= '0;
        wptr  <= '0;
        count <= '0;
      end else begin
        if (do_enq) begin
          pc_q[wptr]   <= fpc;
          data_q[wptr] <= enq_data;
          wptr         <= wptr + PTR_W'(1);
          fpc          <= fpc + 32'd4;
        end
        if (do_deq) begin
          rptr <= rptr + PTR_W'(1);
        end
        if (do_enq && !do_deq) begin
          count <= count + CNT_W'(1);
        end else if (!do_enq && do_deq) begin
          count <= count - CNT_W'(1);
        end
      end
    end
  end

`ifdef IFU_FAULT_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fault_q[i] <= 1'b0;
      end
    end else if (redirect_valid) begin
      misalign_q <= (redirect_pc[1:0] != 2'b00);
    end else if (do_enq) begin
      fault_q[wptr] <= enq_fault;
      misalign_q    <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Table-driven bench for instr_fetch_unit; ROM word k reads as 32'h1000_0000 + k.
// Build with IFU_FAULT_CHECK_EN defined to also check fault tagging.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins_data;
  logic [31:0] ins_pc;
`ifdef IFU_FAULT_CHECK_EN
  logic        ins_fault;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
    logic        ef;
  } vec_t;

  vec_t vecs[$];

  instr_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .DEPTH     (2),
    .IMEM_WORDS(256)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .ins_valid     (ins_valid),
    .ins_ready     (ins_ready),
    .ins_data      (ins_data),
`ifdef IFU_FAULT_CHECK_EN
    .ins_fault     (ins_fault),
`endif
    .ins_pc        (ins_pc)
  );

  assign imem_rdata = 32'h1000_0000 + imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_data(logic [31:0] pc, logic ef);
    logic [31:0] d;
    d = 32'h1000_0000 + {2'b00, pc[31:2]};
`ifdef IFU_FAULT_CHECK_EN
    if (ef) d = 32'h0000_0013;
`else
    if (ef) d = d;
`endif
    return d;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic rv, input logic [31:0] rpc, input logic rdy,
                     input logic ev, input logic [31:0] epc, input logic [31:0] eaddr,
                     input logic ef);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.ev = ev; v.epc = epc; v.eaddr = eaddr; v.ef = ef;
    vecs.push_back(v);
  endtask

  task automatic check_head(input string tag, input logic [31:0] epc, input logic ef);
    check32({tag, " ins_pc"}, ins_pc, epc);
    check32({tag, " ins_data"}, ins_data, exp_data(epc, ef));
`ifdef IFU_FAULT_CHECK_EN
    check32({tag, " ins_fault"}, 32'(ins_fault), 32'(ef));
`endif
  endtask

  initial begin
    // Inputs are applied for the next edge; expectations describe state just after it.
    // Streaming from reset with ready high.
    add(0, 0, 1, 1, 32'h0,  32'h1, 0);
    add(0, 0, 1, 1, 32'h4,  32'h2, 0);
    add(0, 0, 1, 1, 32'h8,  32'h3, 0);
    add(0, 0, 1, 1, 32'hC,  32'h4, 0);
    // Backpressure: fills to DEPTH then freezes.
    add(0, 0, 0, 1, 32'hC,  32'h5, 0);
    add(0, 0, 0, 1, 32'hC,  32'h5, 0);
    add(0, 0, 0, 1, 32'hC,  32'h5, 0);
    add(0, 0, 0, 1, 32'hC,  32'h5, 0);
    add(0, 0, 0, 1, 32'hC,  32'h5, 0);
    add(0, 0, 1, 1, 32'h10, 32'h6, 0);
    add(0, 0, 1, 1, 32'h14, 32'h7, 0);
    add(0, 0, 1, 1, 32'h18, 32'h8, 0);
    // Redirect while full with ready high.
    add(1, 32'h40, 1, 0, 32'h0, 32'h10, 0);
    add(0, 0, 1, 1, 32'h40, 32'h11, 0);
    add(0, 0, 1, 1, 32'h44, 32'h12, 0);
    // Back-to-back redirects: last wins.
    add(1, 32'h20, 1, 0, 32'h0, 32'h8,  0);
    add(1, 32'h80, 1, 0, 32'h0, 32'h20, 0);
    add(0, 0, 1, 1, 32'h80, 32'h21, 0);
    add(0, 0, 1, 1, 32'h84, 32'h22, 0);
    // PC wrap-around at the top of the address space.
    add(1, 32'hFFFF_FFF8, 1, 0, 32'h0, 32'h3FFF_FFFE, 0);
    add(0, 0, 1, 1, 32'hFFFF_FFF8, 32'h3FFF_FFFF, 1);
    add(0, 0, 1, 1, 32'hFFFF_FFFC, 32'h0, 1);
    add(0, 0, 1, 1, 32'h0, 32'h1, 0);
    // Misaligned redirect: low bits dropped, first entry tagged.
    add(1, 32'h106, 1, 0, 32'h0, 32'h41, 0);
    add(0, 0, 1, 1, 32'h104, 32'h42, 1);
    add(0, 0, 1, 1, 32'h108, 32'h43, 0);
    // Crossing the end of the ROM.
    add(1, 32'h3FC, 1, 0, 32'h0, 32'hFF, 0);
    add(0, 0, 1, 1, 32'h3FC, 32'h100, 0);
    add(0, 0, 1, 1, 32'h400, 32'h101, 1);
    add(0, 0, 1, 1, 32'h404, 32'h102, 1);

    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    ins_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check32("reset ins_valid", 32'(ins_valid), 32'd0);
    check32("reset ins_data", ins_data, 32'h0);
    check32("reset ins_pc", ins_pc, 32'h0);
    check32("reset imem_addr", imem_addr, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      ins_ready      = vecs[i].rdy;
      @(posedge clk);
      #1;
      check32($sformatf("v%0d ins_valid", i), 32'(ins_valid), 32'(vecs[i].ev));
      check32($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].eaddr);
      if (vecs[i].ev) check_head($sformatf("v%0d", i), vecs[i].epc, vecs[i].ef);
    end

    // Short mid-stream reset with a redirect pending: both discarded.
    redirect_valid = 1'b0;
    ins_ready = 1'b1;
    @(posedge clk);
    #1;
    check32("pre-reset ins_valid", 32'(ins_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    #2;
    rst_n = 1'b0;
    #1;
    check32("midreset ins_valid", 32'(ins_valid), 32'd0);
    check32("midreset imem_addr", imem_addr, 32'h0);
    redirect_valid = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check32("restart ins_valid", 32'(ins_valid), 32'd1);
    check_head("restart", 32'h0, 1'b0);
    check32("restart imem_addr", imem_addr, 32'h1);
    @(posedge clk);
    #1;
    check_head("restart+1", 32'h4, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
